// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default bit timing.
// Encodings 0-3 are common to the transmitter and receiver FSMs.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  // 115200 baud from a 10 MHz clock
  localparam int DEFAULT_CLK_PER_BIT = 87;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous RX-side inputs.
// Resets to 1 so an idle-high serial line does not look like a start bit.
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data (LSB first), no parity, 1 stop.
// Samples at bit centres and emits one-cycle valid / framing-error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int HALF_BIT = CLK_PER_BIT / 2;
  localparam logic [15:0] HALF_M1 = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLK_PER_BIT - 1);

  logic        rx_s;
  uart_state_e state_q, state_d;
  logic [15:0] clk_count_q, clk_count_d;
  logic [2:0]  bit_index_q, bit_index_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_frame_err_q, rx_frame_err_d;

  uart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      clk_count_q    <= '0;
      bit_index_q    <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      clk_count_q    <= clk_count_d;
      bit_index_q    <= bit_index_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    clk_count_d    = clk_count_q;
    bit_index_d    = bit_index_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          clk_count_d = '0;
          state_d     = START;
        end
      end
      START: begin
        if (clk_count_q == HALF_M1) begin
          clk_count_d = '0;
          state_d     = rx_s ? IDLE : DATA;
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      DATA: begin
        if (clk_count_q == BIT_M1) begin
          clk_count_d          = '0;
          shift_d[bit_index_q] = rx_s;
          if (bit_index_q == 3'd7) begin
            bit_index_d = '0;
            state_d     = STOP;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      STOP: begin
        if (clk_count_q == BIT_M1) begin
          clk_count_d = '0;
          // Returning to IDLE at mid-stop leaves half a bit to catch the next start edge
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            rx_frame_err_d = 1'b1;
            state_d        = BREAK;
          end
        end else begin
          clk_count_d = clk_count_q + 16'd1;
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_busy      = (state_q != IDLE);
    rx_data      = rx_data_q;
    rx_valid     = rx_valid_q;
    rx_frame_err = rx_frame_err_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural serial driver queues expected
// events, and an independent monitor checks each pulse the receiver emits.
module tb_uart_rx;

  typedef struct {
    logic       isErr;
    logic [7:0] data;
    int         startCyc;
    bit         checkLat;
  } expT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxFrameErr;
  logic       rxBusy;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  expT expQ[$];
  bit  prevPulse = 1'b0;

  uart_rx #(.CLK_PER_BIT(87)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rxData),
    .rx_valid     (rxValid),
    .rx_frame_err (rxFrameErr),
    .rx_busy      (rxBusy)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drives one frame starting at a negedge; abortBit >= 0 resets the DUT mid-bit
  // and returns with rst still asserted.
  task automatic applyStimulus(input logic [7:0] data, input int cpb, input logic stopVal, input int abortBit);
    expT e;
    if (abortBit < 0) begin
      e.isErr    = !stopVal;
      e.data     = data;
      e.startCyc = cyc;
      e.checkLat = (cpb == 87) && stopVal;
      expQ.push_back(e);
    end
    rx = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      if (i == abortBit) begin
        repeat (cpb / 2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        return;
      end
      repeat (cpb) @(negedge clk);
    end
    rx = stopVal;
    repeat (cpb) @(negedge clk);
  endtask

  // Monitor: pops one expected event per output pulse
  always @(negedge clk) begin
    if (rxValid || rxFrameErr) begin
      expT e;
      int  lat;
      if (rxValid && rxFrameErr) checkOutput("validAndErrTogether", 1, 0);
      if (prevPulse) checkOutput("pulseTwoCycles", 1, 0);
      if (expQ.size() == 0) begin
        checkOutput("unexpectedPulse", {rxValid, rxFrameErr}, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulseKind", rxFrameErr, e.isErr);
        if (!e.isErr) checkOutput("rxData", rxData, e.data);
        if (e.checkLat) begin
          lat = cyc - e.startCyc - 1;
          if (lat == 827 || lat == 829) lat = 828;
          checkOutput("latency", lat, 828);
        end
      end
    end
    prevPulse <= rxValid || rxFrameErr;
  end

  initial begin
    // Reset with rx toggling
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rx = ~rx;
    end
    checkOutput("resetData", rxData, 8'h00);
    checkOutput("resetValid", rxValid, 0);
    checkOutput("resetErr", rxFrameErr, 0);
    checkOutput("resetBusy", rxBusy, 0);
    rx  = 1'b1;
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // Back-to-back loopback frames
    applyStimulus(8'hA5, 87, 1'b1, -1);
    applyStimulus(8'h00, 87, 1'b1, -1);
    applyStimulus(8'hFF, 87, 1'b1, -1);
    repeat (20) @(negedge clk);
    checkOutput("dataAfterLoopback", rxData, 8'hFF);

    // Start glitch
    rx = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("glitchBusyHigh", rxBusy, 1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("glitchBusyLow", rxBusy, 0);
    checkOutput("glitchDataKept", rxData, 8'hFF);
    repeat (100) @(negedge clk);

    // Framing error followed by a held-low line
    applyStimulus(8'h3C, 87, 1'b0, -1);
    repeat (300) @(negedge clk);
    checkOutput("breakBusy", rxBusy, 1);
    checkOutput("errDataKept", rxData, 8'hFF);
    rx = 1'b1;
    repeat (87) @(negedge clk);
    checkOutput("breakReleased", rxBusy, 0);
    applyStimulus(8'h5A, 87, 1'b1, -1);
    repeat (100) @(negedge clk);

    // Reset during data bit 4
    applyStimulus(8'h96, 87, 1'b1, 4);
    checkOutput("midResetBusy", rxBusy, 0);
    checkOutput("midResetData", rxData, 8'h00);
    checkOutput("midResetValid", rxValid, 0);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    applyStimulus(8'h96, 87, 1'b1, -1);
    repeat (100) @(negedge clk);

    // Transmitter clock skew
    applyStimulus(8'hC3, 85, 1'b1, -1);
    repeat (100) @(negedge clk);
    applyStimulus(8'hC3, 89, 1'b1, -1);

    for (int i = 0; i < 2000 && expQ.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    checkOutput("pendingExpected", expQ.size(), 0);
    checkOutput("finalData", rxData, 8'hC3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
